valve_lut_ctrl: RTL and testbench
=================================

// Module: valve_lut_ctrl
// PURPOSE
//  Downstream of the data sorter. Takes its 9-bit state address {temp_state, change_state, time_state},
//  looks up a 6-bit valve setting in a loadable trained-policy table and slews valve_out toward it.
//  Invalid state codes raise a fault flag and leave the valve where it is.
// PARAMETERS
//  ADDR_W     9   state address width (three 3-bit fields)
//  VALVE_W    6   valve setting width
//  MAX_STEP   4   max |change| of valve_out per applied step (1..2^VALVE_W-1)
//  STEP_DIV   8   clk cycles between slew steps (>=1)
//  INIT_VALVE 0   valve_out after reset and table content after reset
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  addr_in    in   ADDR_W   state address from data sorter
//  addr_vld   in   1        addr_in valid this cycle
//  cfg_we     in   1        table write strobe
//  cfg_addr   in   ADDR_W   table write address
//  cfg_data   in   VALVE_W  table write data
//  valve_out  out  VALVE_W  registered valve command
//  target     out  VALVE_W  current looked-up target (registered)
//  at_target  out  1        valve_out == target
//  fault      out  1        sticky: invalid state field seen
// BEHAVIOUR
//  - Reset (sync, any cycle, incl. mid-slew): valve_out=target=INIT_VALVE, at_target=1, fault=0,
//    step counter=0, pipeline valid=0; every table entry reset to INIT_VALVE (register array).
//  - Field check: each 3-bit field of addr_in must be 1, 2 or 3; a 0 or >=4 field is invalid.
//  - Pipeline: cycle N addr_vld=1 -> N+1 table read registered -> N+2 target updated.
//    Invalid addr: no target update, fault set at N+1, clears only on rst.
//    A valid addr after an invalid one updates target normally; fault stays set.
//  - addr_vld=0: target holds; slewing continues toward held target.
//  - Write/read same entry same cycle: read returns OLD data (read-before-write); write lands next cycle.
//  - cfg_we at an invalid address still writes (table fully addressable); no fault from cfg path.
//  - Slew: free-running counter 0..STEP_DIV-1; on wrap (count==STEP_DIV-1) apply one step:
//    diff=target-valve_out (signed, VALVE_W+1 bits); |diff|<=MAX_STEP -> valve_out=target,
//    else valve_out +/- MAX_STEP. Never overshoots, never wraps past 0 or 2^VALVE_W-1.
//  - Target change mid-slew: next step uses new target; counter not restarted.
//  - at_target combinational compare of registered valve_out and target.
// CONFIGURATION
//  VALVE_OVERRIDE_EN defined: extra ports ovr_en (in,1), ovr_val (in,VALVE_W). While ovr_en=1,
//    valve_out=ovr_val next cycle (no slew), at_target forced 0, lookup/target still tracked.
//    On ovr_en falling, slew resumes from ovr_val toward target at next counter wrap.
//  Undefined: ports absent; valve_out driven only by slew logic.
// TESTING
//  1 Reset: rst=1 mid-slew (valve_out=20,target=40) -> next cycle valve_out=0,target=0,fault=0.
//  2 Lookup latency: load entry 9'b001_010_011=40, pulse addr_vld with it at N -> target=40 at N+2.
//  3 Slew: target 40 from 0, MAX_STEP=4, STEP_DIV=8 -> +4 every 8 cycles, reaches 40 after 10 steps,
//    at_target=1; then target 2 -> steps down by 4 to 4, final step lands exactly on 2.
//  4 Invalid: addr 9'b000_010_011 -> fault=1 at N+1, target unchanged; later valid addr updates target, fault stays 1.
//  5 Collision: cfg_we to addr A with 55 while addr_vld=A, old=12 -> target=12; repeat read -> 55.
//  6 VALVE_OVERRIDE_EN: ovr_en=1,ovr_val=63 -> valve_out=63 next cycle; release -> slews down to target by MAX_STEP.

Source files
------------

// File: rtl/valve_lut_ctrl.sv
// Policy-table valve controller: target 2 cycles after addr_vld, valve_out slews one step per STEP_DIV cycles; no backpressure.
// Optional macro VALVE_OVERRIDE_EN adds ovr_en/ovr_val direct valve override.
module valve_lut_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int VALVE_W    = 6,
  parameter int MAX_STEP   = 4,
  parameter int STEP_DIV   = 8,
  parameter int INIT_VALVE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic               addr_vld,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [VALVE_W-1:0] cfg_data,
`ifdef VALVE_OVERRIDE_EN
  input  logic               ovr_en,
  input  logic [VALVE_W-1:0] ovr_val,
`endif
  output logic [VALVE_W-1:0] valve_out,
  output logic [VALVE_W-1:0] target,
  output logic               at_target,
  output logic               fault
);

  localparam int FW    = ADDR_W / 3;
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [VALVE_W-1:0] INIT_V   = VALVE_W'(INIT_VALVE);
  localparam logic [VALVE_W-1:0] STEP_V   = VALVE_W'(MAX_STEP);
  localparam logic [VALVE_W:0]   STEP_LIM = {1'b0, STEP_V};

  function automatic logic field_ok(input logic [FW-1:0] f);
    return (f != '0) && (f <= FW'(3));
  endfunction

  logic                addr_ok;
  logic [VALVE_W-1:0]  tbl [2**ADDR_W];
  logic                rd_vld;
  logic [VALVE_W-1:0]  rd_dat;
  logic [CNT_W-1:0]    cnt;
  logic                wrap;
  logic signed [VALVE_W:0] diff;
  logic [VALVE_W:0]    mag;
  logic [VALVE_W-1:0]  slew_nxt;
  logic                ovr_act;
  logic [VALVE_W-1:0]  ovr_dat;

`ifdef VALVE_OVERRIDE_EN
  assign ovr_act = ovr_en;
  assign ovr_dat = ovr_val;
`else
  assign ovr_act = 1'b0;
  assign ovr_dat = '0;
`endif

  assign addr_ok = field_ok(addr_in[FW-1:0]) && field_ok(addr_in[2*FW-1:FW])
                && field_ok(addr_in[3*FW-1:2*FW]);

  // Plain register array so every entry can be reset; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) tbl[i] <= INIT_V;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_dat <= INIT_V;
      fault  <= 1'b0;
      target <= INIT_V;
    end else begin
      rd_vld <= addr_vld && addr_ok;
      if (addr_vld) rd_dat <= tbl[addr_in];
      if (addr_vld && !addr_ok) fault <= 1'b1;
      if (rd_vld) target <= rd_dat;
    end
  end

  assign wrap = (cnt == CNT_W'(STEP_DIV - 1));
  assign diff = $signed({1'b0, target}) - $signed({1'b0, valve_out});
  assign mag  = diff[VALVE_W] ? unsigned'(-diff) : unsigned'(diff);

  // Large gaps move by exactly MAX_STEP, so the result stays strictly between valve_out and target.
  always_comb begin
    slew_nxt = valve_out;
    if (mag <= STEP_LIM)     slew_nxt = target;
    else if (diff[VALVE_W])  slew_nxt = valve_out - STEP_V;
    else                     slew_nxt = valve_out + STEP_V;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      valve_out <= INIT_V;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (ovr_act)   valve_out <= ovr_dat;
      else if (wrap) valve_out <= slew_nxt;
    end
  end

  assign at_target = (valve_out == target) && !ovr_act;

endmodule

// File: tb/tb_valve_lut_ctrl.sv
// Scoreboard bench for valve_lut_ctrl: stimulus queues expected lookup results, a negedge monitor retires and checks them.
// Build with VALVE_OVERRIDE_EN defined to also exercise the override ports.
module tb_valve_lut_ctrl;
  localparam int ADDR_W = 9, VALVE_W = 6, MAX_STEP = 4, STEP_DIV = 8, INIT_VALVE = 0;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] addr_in, cfg_addr;
  logic addr_vld, cfg_we;
  logic [VALVE_W-1:0] cfg_data, valve_out, target;
  logic at_target, fault;
`ifdef VALVE_OVERRIDE_EN
  logic ovr_en;
  logic [VALVE_W-1:0] ovr_val;
`endif

  valve_lut_ctrl #(.ADDR_W(ADDR_W), .VALVE_W(VALVE_W), .MAX_STEP(MAX_STEP),
                   .STEP_DIV(STEP_DIV), .INIT_VALVE(INIT_VALVE)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .addr_vld(addr_vld),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef VALVE_OVERRIDE_EN
    .ovr_en(ovr_en), .ovr_val(ovr_val),
`endif
    .valve_out(valve_out), .target(target), .at_target(at_target), .fault(fault));

  always #5 clk = ~clk;

  typedef struct { int due; bit is_fault; int val; } exp_t;
  exp_t sbq[$];
  int mdl_tbl [2**ADDR_W];
  int edge_cnt = 0, since_rst = 0;
  bit mdl_ok = 0, smp_rst = 0, smp_ovr = 0;
  int smp_ovr_val = 0;
  int exp_valve = 0, exp_target = 0;
  bit exp_fault = 0;
  int n_chk = 0, n_fail = 0;

  function automatic void chk(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, got, exp);
    end
  endfunction

  function automatic bit addr_good(int a);
    for (int k = 0; k < 3; k++) begin
      int f = (a >> (3 * k)) & 7;
      if (f < 1 || f > 3) return 0;
    end
    return 1;
  endfunction

  function automatic int slew_to(int v, int t);
    int d = t - v;
    if (d > MAX_STEP)  return v + MAX_STEP;
    if (d < -MAX_STEP) return v - MAX_STEP;
    return t;
  endfunction

  function automatic int rand_addr();
    int a = ($urandom_range(1, 3) << 6) | ($urandom_range(1, 3) << 3) | $urandom_range(1, 3);
    if ($urandom_range(0, 9) == 0) a = a & ~(7 << (3 * $urandom_range(0, 2))) | (($urandom_range(0, 1) * 4) << (3 * $urandom_range(0, 2)));
    return a & 511;
  endfunction

  // Capture what the DUT saw at each rising edge.
  always @(posedge clk) begin
    edge_cnt++;
    smp_rst = rst;
`ifdef VALVE_OVERRIDE_EN
    smp_ovr = ovr_en;
    smp_ovr_val = int'(ovr_val);
`endif
  end

  always @(negedge clk) begin
    exp_t e;
    bit ovr_now;
    ovr_now = 0;
`ifdef VALVE_OVERRIDE_EN
    ovr_now = ovr_en;
`endif
    if (smp_rst) begin
      exp_valve = INIT_VALVE; exp_target = INIT_VALVE; exp_fault = 0;
      since_rst = 0; sbq.delete(); mdl_ok = 1;
    end else if (mdl_ok) begin
      since_rst++;
      if (smp_ovr) exp_valve = smp_ovr_val;
      else if (since_rst % STEP_DIV == 0) exp_valve = slew_to(exp_valve, exp_target);
      while (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
        e = sbq.pop_front();
        if (e.is_fault) exp_fault = 1;
        else exp_target = e.val;
      end
    end
    if (mdl_ok) begin
      chk("target", int'(target), exp_target);
      chk("fault", int'(fault), int'(exp_fault));
      chk("valve_out", int'(valve_out), exp_valve);
      chk("at_target", int'(at_target), int'(exp_valve == exp_target && !ovr_now));
    end
  end

  task automatic drive(input bit vld, input int a, input bit we, input int wa, input int wd);
    exp_t e;
    addr_vld = vld; addr_in = 9'(a); cfg_we = we; cfg_addr = 9'(wa); cfg_data = 6'(wd);
    if (vld) begin
      if (addr_good(a)) begin e.due = edge_cnt + 2; e.is_fault = 0; e.val = mdl_tbl[a]; end
      else begin e.due = edge_cnt + 1; e.is_fault = 1; e.val = 0; end
      sbq.push_back(e);
    end
    if (we) mdl_tbl[wa] = wd;
    @(posedge clk); #1;
    addr_vld = 0; cfg_we = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    foreach (mdl_tbl[i]) mdl_tbl[i] = INIT_VALVE;
    @(posedge clk); #1;
    rst = 0;
  endtask

  localparam int A1 = 9'b001_010_011;
  localparam int B1 = 9'b011_011_011;
  localparam int C1 = 9'b010_001_010;
  localparam int BAD = 9'b000_010_011;

  initial begin
    addr_vld = 0; addr_in = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
`ifdef VALVE_OVERRIDE_EN
    ovr_en = 0; ovr_val = 0;
`endif
    do_reset();
    idle(3);
    // Lookup latency, then slew 0 -> 40 -> 2.
    drive(0, 0, 1, A1, 40);
    drive(1, A1, 0, 0, 0);
    idle(90);
    drive(0, 0, 1, B1, 2);
    drive(1, B1, 0, 0, 0);
    idle(100);
    // Invalid field sets sticky fault; a later valid lookup still updates target.
    drive(1, BAD, 0, 0, 0);
    idle(3);
    drive(1, A1, 0, 0, 0);
    idle(5);
    // Same-cycle write and read of one entry returns the old value.
    drive(0, 0, 1, C1, 12);
    drive(1, C1, 1, C1, 55);
    idle(2);
    drive(1, C1, 0, 0, 0);
    idle(3);
    // Reset in the middle of a slew.
    do_reset();
    drive(0, 0, 1, A1, 40);
    drive(1, A1, 0, 0, 0);
    for (int k = 0; k < 200 && exp_valve != 20; k++) idle(1);
    do_reset();
    idle(3);
`ifdef VALVE_OVERRIDE_EN
    drive(0, 0, 1, A1, 10);
    drive(1, A1, 0, 0, 0);
    idle(20);
    ovr_en = 1; ovr_val = 63;
    idle(3);
    ovr_en = 0;
    idle(150);
`endif
    for (int i = 0; i < 1500; i++) begin
      int a, wa;
      bit vld, we;
      if (i == 700) do_reset();
      a = rand_addr();
      wa = ($urandom_range(0, 3) == 0) ? a : rand_addr();
      vld = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 5) == 0);
`ifdef VALVE_OVERRIDE_EN
      if ($urandom_range(0, 59) == 0) begin
        ovr_en = !ovr_en;
        ovr_val = 6'($urandom_range(0, 63));
      end
`endif
      drive(vld, a, we, wa, $urandom_range(0, 63));
    end
`ifdef VALVE_OVERRIDE_EN
    ovr_en = 0;
`endif
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
